// File: rtl/ysyx_22041207_rd_arbiter.sv
// Read-channel arbiter: shares one AXI read bridge between instruction fetch (IF) and data load (MEM).
// One whole transaction (address + data) is granted at a time; MEM has priority, bounded by a streak limit.
module ysyx_22041207_rd_arbiter #(
  parameter int unsigned MAX_MEM_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  // IF requester
  input  logic        if_r_valid_i,
  output logic        if_r_ready_o,
  input  logic [63:0] if_r_addr_i,
  input  logic [7:0]  if_r_size_i,
  output logic [63:0] if_data_read_o,
  output logic        if_data_valid,
  input  logic        if_data_ready,
  // MEM requester
  input  logic        mem_r_valid_i,
  output logic        mem_r_ready_o,
  input  logic [63:0] mem_r_addr_i,
  input  logic [7:0]  mem_r_size_i,
  output logic [63:0] mem_data_read_o,
  output logic        mem_data_valid,
  input  logic        mem_data_ready,
  // bridge side
  output logic        ds_r_valid_i,
  input  logic        ds_r_ready_o,
  output logic [63:0] ds_r_addr_i,
  output logic [7:0]  ds_r_size_i,
  input  logic [63:0] ds_data_read_o,
  input  logic        ds_data_valid,
  output logic        ds_data_ready,
  // status
  output logic        grant_mem,
  output logic        busy
);

  localparam int unsigned SW = $clog2(MAX_MEM_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_MEM_STREAK);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA
  } state_e;

  state_e        state_q;
  logic          ds_r_valid_q;
  logic          grant_mem_q;
  logic [63:0]   addr_q;
  logic [7:0]    size_q;
  logic [SW-1:0] streak_q;

  logic          pick_mem;
  logic          in_addr;
  logic          in_data;
  logic          ds_rdy;

  // MEM wins unless IF has waited through a full streak of MEM grants.
  assign pick_mem = mem_r_valid_i && !(if_r_valid_i && (streak_q == STREAK_MAX));

  assign in_addr = (state_q == S_ADDR);
  assign in_data = (state_q == S_DATA);
  assign ds_rdy  = in_data && (grant_mem_q ? mem_data_ready : if_data_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      ds_r_valid_q <= 1'b0;
      grant_mem_q  <= 1'b0;
      addr_q       <= '0;
      size_q       <= '0;
      streak_q     <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (if_r_valid_i || mem_r_valid_i) begin
            state_q      <= S_ADDR;
            ds_r_valid_q <= 1'b1;
            grant_mem_q  <= pick_mem;
            addr_q       <= pick_mem ? mem_r_addr_i : if_r_addr_i;
            size_q       <= pick_mem ? mem_r_size_i : if_r_size_i;
            // pick_mem with IF waiting implies streak_q < STREAK_MAX, so no wrap.
            if (pick_mem && if_r_valid_i) streak_q <= streak_q + 1'b1;
            else                          streak_q <= '0;
          end
        end
        S_ADDR: begin
          if (ds_r_ready_o) begin
            ds_r_valid_q <= 1'b0;
            state_q      <= S_DATA;
          end
        end
        S_DATA: begin
          if (ds_data_valid && ds_rdy) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ds_r_valid_i    = ds_r_valid_q;
  assign ds_r_addr_i     = addr_q;
  assign ds_r_size_i     = size_q;
  assign ds_data_ready   = ds_rdy;
  assign grant_mem       = grant_mem_q;
  assign busy            = (state_q != S_IDLE);

  assign if_r_ready_o    = in_addr && !grant_mem_q && ds_r_ready_o;
  assign mem_r_ready_o   = in_addr &&  grant_mem_q && ds_r_ready_o;

  assign if_data_valid   = in_data && !grant_mem_q && ds_data_valid;
  assign mem_data_valid  = in_data &&  grant_mem_q && ds_data_valid;
  assign if_data_read_o  = ds_data_read_o;
  assign mem_data_read_o = ds_data_read_o;

endmodule

// File: tb/tb_ysyx_22041207_rd_arbiter.sv
// Scoreboard bench for the read arbiter: requester drivers, a bridge model, and a monitor that
// checks every grant and data beat against hand-ordered expectations.
module tb_ysyx_22041207_rd_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_r_valid_i, if_r_ready_o, if_data_valid, if_data_ready;
  logic [63:0] if_r_addr_i, if_data_read_o;
  logic [7:0]  if_r_size_i;
  logic        mem_r_valid_i, mem_r_ready_o, mem_data_valid, mem_data_ready;
  logic [63:0] mem_r_addr_i, mem_data_read_o;
  logic [7:0]  mem_r_size_i;
  logic        ds_r_valid_i, ds_r_ready_o, ds_data_valid, ds_data_ready;
  logic [63:0] ds_r_addr_i, ds_data_read_o;
  logic [7:0]  ds_r_size_i;
  logic        grant_mem, busy;

  always #5 clk = ~clk;

  ysyx_22041207_rd_arbiter #(.MAX_MEM_STREAK(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_r_valid_i(if_r_valid_i), .if_r_ready_o(if_r_ready_o), .if_r_addr_i(if_r_addr_i),
    .if_r_size_i(if_r_size_i), .if_data_read_o(if_data_read_o), .if_data_valid(if_data_valid),
    .if_data_ready(if_data_ready),
    .mem_r_valid_i(mem_r_valid_i), .mem_r_ready_o(mem_r_ready_o), .mem_r_addr_i(mem_r_addr_i),
    .mem_r_size_i(mem_r_size_i), .mem_data_read_o(mem_data_read_o), .mem_data_valid(mem_data_valid),
    .mem_data_ready(mem_data_ready),
    .ds_r_valid_i(ds_r_valid_i), .ds_r_ready_o(ds_r_ready_o), .ds_r_addr_i(ds_r_addr_i),
    .ds_r_size_i(ds_r_size_i), .ds_data_read_o(ds_data_read_o), .ds_data_valid(ds_data_valid),
    .ds_data_ready(ds_data_ready),
    .grant_mem(grant_mem), .busy(busy)
  );

  typedef struct {
    bit          mem;
    logic [63:0] addr;
    logic [7:0]  size;
    logic [63:0] data;
  } exp_t;

  typedef struct {
    logic [63:0] addr;
    logic [7:0]  size;
  } req_t;

  exp_t aq[$];
  exp_t dq[$];
  req_t if_pend[$];
  req_t mem_pend[$];
  int   checks = 0;
  int   errors = 0;
  int   if_beats = 0;
  int   mem_beats = 0;
  int   ar_lat = 0;
  int   d_lat = 1;
  int   bst = 0;

  localparam logic [63:0] XK = 64'hA5A5_0000_0000_0000;

  // Bridge memory image: one fixed word at the reset vector, a keyed pattern elsewhere.
  function automatic logic [63:0] rdata(input logic [63:0] a);
    return (a == 64'h8000_0000) ? 64'h13 : (a ^ XK);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic bound_chk(input string name, input bit ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: wait bound expired, expected the event to occur", name);
    end
  endtask

  task automatic push_req(input bit m, input logic [63:0] a, input logic [7:0] s);
    req_t r;
    r.addr = a;
    r.size = s;
    if (m) mem_pend.push_back(r);
    else   if_pend.push_back(r);
  endtask

  task automatic push_exp(input bit m, input logic [63:0] a, input logic [7:0] s, input logic [63:0] d);
    exp_t e;
    e.mem = m; e.addr = a; e.size = s; e.data = d;
    aq.push_back(e);
    dq.push_back(e);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    bit pending;
    n = 0;
    pending = 1'b1;
    while (pending && n < budget) begin
      @(negedge clk);
      n++;
      pending = (aq.size() != 0) || (dq.size() != 0) || (if_pend.size() != 0) ||
                (mem_pend.size() != 0) || busy;
    end
    bound_chk({name, "_drain"}, !pending);
    if (pending) begin
      aq.delete();
      dq.delete();
    end
  endtask

  // IF requester: holds valid/addr/size until accepted.
  initial begin : if_drv
    bit hs;
    if_r_valid_i = 1'b0; if_r_addr_i = '0; if_r_size_i = '0;
    forever begin
      @(negedge clk);
      hs = if_r_valid_i && if_r_ready_o;
      @(posedge clk); #1;
      if (!rst_n) if_pend.delete();
      else if (hs && if_pend.size() > 0) void'(if_pend.pop_front());
      if (if_pend.size() > 0) begin
        if_r_valid_i = 1'b1; if_r_addr_i = if_pend[0].addr; if_r_size_i = if_pend[0].size;
      end else begin
        if_r_valid_i = 1'b0;
      end
    end
  end

  initial begin : mem_drv
    bit hs;
    mem_r_valid_i = 1'b0; mem_r_addr_i = '0; mem_r_size_i = '0;
    forever begin
      @(negedge clk);
      hs = mem_r_valid_i && mem_r_ready_o;
      @(posedge clk); #1;
      if (!rst_n) mem_pend.delete();
      else if (hs && mem_pend.size() > 0) void'(mem_pend.pop_front());
      if (mem_pend.size() > 0) begin
        mem_r_valid_i = 1'b1; mem_r_addr_i = mem_pend[0].addr; mem_r_size_i = mem_pend[0].size;
      end else begin
        mem_r_valid_i = 1'b0;
      end
    end
  end

  // Bridge model: address accepted after ar_lat cycles, data returned d_lat cycles later.
  initial begin : bridge
    bit ar_hs, d_hs;
    int wc;
    logic [63:0] cap;
    ds_r_ready_o = 1'b0; ds_data_valid = 1'b0; ds_data_read_o = '0;
    wc = 0; cap = '0;
    forever begin
      @(negedge clk);
      ar_hs = ds_r_valid_i && ds_r_ready_o;
      d_hs  = ds_data_valid && ds_data_ready;
      if (rst_n && bst == 1 && !ar_hs) begin
        chk("addr_hold_valid", ds_r_valid_i, 1);
        chk("addr_hold_addr", ds_r_addr_i, cap);
      end
      @(posedge clk); #1;
      if (!rst_n) begin
        bst = 0; ds_r_ready_o = 1'b0; ds_data_valid = 1'b0;
      end else begin
        case (bst)
          0: if (ds_r_valid_i) begin
            bst = 1; wc = 0; cap = ds_r_addr_i; ds_r_ready_o = (ar_lat == 0);
          end
          1: if (ar_hs) begin
            ds_r_ready_o = 1'b0; bst = 2; wc = 0;
            if (d_lat == 0) begin ds_data_valid = 1'b1; ds_data_read_o = rdata(ds_r_addr_i); end
          end else begin
            wc++;
            if (wc >= ar_lat) ds_r_ready_o = 1'b1;
          end
          2: if (d_hs) begin
            ds_data_valid = 1'b0; bst = 0;
          end else if (!ds_data_valid) begin
            wc++;
            if (wc >= d_lat) begin ds_data_valid = 1'b1; ds_data_read_o = rdata(ds_r_addr_i); end
          end
          default: bst = 0;
        endcase
      end
    end
  end

  // Monitor: pops the address scoreboard on each bridge address handshake and the data
  // scoreboard on each requester data handshake.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (if_data_valid && if_data_ready)   if_beats++;
        if (mem_data_valid && mem_data_ready) mem_beats++;
        if (ds_r_valid_i) begin
          if (aq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_grant: addr %0h presented, expected no request", ds_r_addr_i);
          end else begin
            e = aq[0];
            chk("if_r_ready", if_r_ready_o, ds_r_ready_o && !e.mem);
            chk("mem_r_ready", mem_r_ready_o, ds_r_ready_o && e.mem);
            if (ds_r_ready_o) begin
              void'(aq.pop_front());
              chk("grant_mem", grant_mem, e.mem);
              chk("ds_r_addr", ds_r_addr_i, e.addr);
              chk("ds_r_size", ds_r_size_i, e.size);
            end
          end
        end else begin
          chk("r_ready_idle", if_r_ready_o | mem_r_ready_o, 0);
        end
        if (ds_data_valid) begin
          if (dq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_data: bridge data with no transaction expected");
          end else begin
            e = dq[0];
            chk("if_data_valid", if_data_valid, !e.mem);
            chk("mem_data_valid", mem_data_valid, e.mem);
            chk("ds_data_ready", ds_data_ready, e.mem ? mem_data_ready : if_data_ready);
            if (ds_data_ready) begin
              void'(dq.pop_front());
              chk("rdata", e.mem ? mem_data_read_o : if_data_read_o, e.data);
            end
          end
        end else begin
          chk("data_valid_idle", if_data_valid | mem_data_valid, 0);
        end
      end
    end
  end

  bit t3_ord[11] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1};
  bit t7_ord[6]  = '{1, 1, 1, 1, 0, 1};

  initial begin : stim
    int n, ib, mb, mi, ii;
    logic [63:0] a;
    if_data_ready = 1'b1; mem_data_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_ds_r_valid", ds_r_valid_i, 0);
    chk("rst_ds_data_ready", ds_data_ready, 0);
    chk("rst_ds_r_addr", ds_r_addr_i, 0);
    chk("rst_ds_r_size", ds_r_size_i, 0);
    chk("rst_grant_mem", grant_mem, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: IF alone, one-cycle request latency
    ar_lat = 0; d_lat = 1; ib = if_beats; mb = mem_beats;
    @(negedge clk);
    push_exp(0, 64'h8000_0000, 8'h0F, 64'h13);
    push_req(0, 64'h8000_0000, 8'h0F);
    n = 0;
    do begin @(posedge clk); #2; n++; end while (!if_r_valid_i && n < 20);
    bound_chk("t1_valid_seen", if_r_valid_i);
    @(negedge clk);
    chk("t1_no_comb_path", ds_r_valid_i, 0);
    @(negedge clk);
    chk("t1_ds_r_valid", ds_r_valid_i, 1);
    chk("t1_ds_r_addr", ds_r_addr_i, 64'h8000_0000);
    wait_idle("t1", 50);
    chk("t1_if_beats", if_beats - ib, 1);
    chk("t1_mem_beats", mem_beats - mb, 0);

    // 2: simultaneous requests, MEM first
    ib = if_beats; mb = mem_beats;
    @(negedge clk);
    push_exp(1, 64'h8000_1000, 8'hFF, 64'hA5A5_0000_8000_1000);
    push_exp(0, 64'h8000_0004, 8'h0F, 64'hA5A5_0000_8000_0004);
    push_req(0, 64'h8000_0004, 8'h0F);
    push_req(1, 64'h8000_1000, 8'hFF);
    wait_idle("t2", 60);
    chk("t2_if_beats", if_beats - ib, 1);
    chk("t2_mem_beats", mem_beats - mb, 1);

    // 3: both requesters saturated; streak limit forces IF every fifth grant
    @(negedge clk);
    mi = 0; ii = 0;
    for (int k = 0; k < 11; k++) begin
      if (t3_ord[k]) begin
        a = 64'h8000_2000 + 64'(8 * mi); mi++;
        push_exp(1, a, 8'hFF, a ^ XK);
        push_req(1, a, 8'hFF);
      end else begin
        a = 64'h8000_0100 + 64'(4 * ii); ii++;
        push_exp(0, a, 8'h0F, a ^ XK);
        push_req(0, a, 8'h0F);
      end
    end
    wait_idle("t3", 200);

    // 4: bridge stalls the address phase for 5 cycles
    ar_lat = 5;
    @(negedge clk);
    push_exp(1, 64'h8000_3000, 8'h03, 64'hA5A5_0000_8000_3000);
    push_req(1, 64'h8000_3000, 8'h03);
    wait_idle("t4", 60);
    ar_lat = 0;

    // 5: IF withholds data_ready for 3 cycles
    @(negedge clk);
    if_data_ready = 1'b0;
    push_exp(0, 64'h8000_0200, 8'h0F, 64'hA5A5_0000_8000_0200);
    push_req(0, 64'h8000_0200, 8'h0F);
    n = 0;
    while (!ds_data_valid && n < 50) begin @(negedge clk); n++; end
    bound_chk("t5_data_seen", ds_data_valid);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      chk("t5_ds_data_ready", ds_data_ready, 0);
      chk("t5_busy", busy, 1);
      chk("t5_if_data_valid", if_data_valid, 1);
    end
    @(posedge clk); #1;
    if_data_ready = 1'b1;
    wait_idle("t5", 30);

    // 6: reset in the middle of a MEM data phase
    d_lat = 8;
    @(negedge clk);
    push_exp(1, 64'h8000_4000, 8'hFF, 64'hA5A5_0000_8000_4000);
    push_req(1, 64'h8000_4000, 8'hFF);
    n = 0;
    do begin @(posedge clk); #2; n++; end while (bst != 2 && n < 50);
    bound_chk("t6_data_phase", bst == 2);
    @(posedge clk); #2;
    chk("t6_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_ds_r_valid", ds_r_valid_i, 0);
    chk("t6_ds_data_ready", ds_data_ready, 0);
    chk("t6_ds_r_addr", ds_r_addr_i, 0);
    chk("t6_ds_r_size", ds_r_size_i, 0);
    chk("t6_grant_mem", grant_mem, 0);
    chk("t6_busy", busy, 0);
    chk("t6_mem_data_valid", mem_data_valid, 0);
    aq.delete();
    dq.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    d_lat = 1;
    @(negedge clk);
    push_exp(0, 64'h8000_0300, 8'h0F, 64'hA5A5_0000_8000_0300);
    push_req(0, 64'h8000_0300, 8'h0F);
    wait_idle("t6", 40);

    // 7: MEM grants with IF idle must not build a streak
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      a = 64'h8000_5000 + 64'(8 * k);
      push_exp(1, a, 8'hFF, a ^ XK);
      push_req(1, a, 8'hFF);
    end
    wait_idle("t7a", 60);
    @(negedge clk);
    mi = 0;
    for (int k = 0; k < 6; k++) begin
      if (t7_ord[k]) begin
        a = 64'h8000_6000 + 64'(8 * mi); mi++;
        push_exp(1, a, 8'hFF, a ^ XK);
        push_req(1, a, 8'hFF);
      end else begin
        push_exp(0, 64'h8000_0400, 8'h0F, 64'hA5A5_0000_8000_0400);
        push_req(0, 64'h8000_0400, 8'h0F);
      end
    end
    wait_idle("t7b", 100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: run still active at %0t, expected completion", $time);
    $fatal(1);
  end

endmodule
